// File: rtl/trg_mon_pkg.sv
//------------------------------------------------------------------------------
// Module      : trg_mon_pkg
// Description : Shared word width and read-back address map for the trigger
//               board monitor multiplexer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package trg_mon_pkg;

   localparam int DW = 16;

   localparam logic [7:0] ADDR_CTRL_REG           = 8'd24;
   localparam logic [7:0] ADDR_CMD_REG            = 8'd25;
   localparam logic [7:0] ADDR_TRG_MODE_MIP1      = 8'd26;
   localparam logic [7:0] ADDR_TRG_MODE_MIP2      = 8'd27;
   localparam logic [7:0] ADDR_TRG_MODE_GM1       = 8'd28;
   localparam logic [7:0] ADDR_TRG_MODE_GM2       = 8'd29;
   localparam logic [7:0] ADDR_TRG_MODE_UBS       = 8'd30;
   localparam logic [7:0] ADDR_TRG_MODE_BRST      = 8'd31;
   localparam logic [7:0] ADDR_EFF_TRG_CNT        = 8'd32;
   localparam logic [7:0] ADDR_COINCID_TRG_CNT    = 8'd33;
   localparam logic [7:0] ADDR_HIT_MONIT_FIX_SEL  = 8'd34;
   localparam logic [7:0] ADDR_HIT_MONIT_SEL      = 8'd35;
   localparam logic [7:0] ADDR_HIT_MONIT_ERR_CNT  = 8'd36;
   localparam logic [7:0] ADDR_HIT_START_CNT      = 8'd37;
   localparam logic [7:0] ADDR_HIT_MONIT_CNT_0_LO = 8'd38;
   localparam logic [7:0] ADDR_HIT_MONIT_CNT_0_HI = 8'd39;
   localparam logic [7:0] ADDR_HIT_MONIT_CNT_1_LO = 8'd40;
   localparam logic [7:0] ADDR_HIT_MONIT_CNT_1_HI = 8'd41;
   localparam logic [7:0] ADDR_BUSY_MONIT_FIX_SEL = 8'd42;
   localparam logic [7:0] ADDR_BUSY_MONIT_ERR_CNT = 8'd43;
   localparam logic [7:0] ADDR_BUSY_MONIT_CNT     = 8'd44;
   localparam logic [7:0] ADDR_COINCID_MIP1       = 8'd45;
   localparam logic [7:0] ADDR_COINCID_MIP2       = 8'd46;
   localparam logic [7:0] ADDR_COINCID_GM1        = 8'd47;
   localparam logic [7:0] ADDR_COINCID_GM2        = 8'd48;
   localparam logic [7:0] ADDR_COINCID_UBS_LO     = 8'd49;
   localparam logic [7:0] ADDR_COINCID_UBS_HI     = 8'd50;
   localparam logic [7:0] ADDR_LOGIC_MATCH_CNT    = 8'd51;
   localparam logic [7:0] ADDR_EXT_TRG_CNT        = 8'd52;
   localparam logic [7:0] ADDR_HIT_AB_SEL         = 8'd53;
   localparam logic [7:0] ADDR_BUSY_AB_SEL        = 8'd54;
   localparam logic [7:0] ADDR_HIT_MASK           = 8'd55;
   localparam logic [7:0] ADDR_BUSY_MASK          = 8'd56;
   localparam logic [7:0] ADDR_TRG_MATCH_WIN      = 8'd57;
   localparam logic [7:0] ADDR_TRG_DEAD_TIME      = 8'd58;
   localparam logic [7:0] ADDR_CONFIG_RECEIVED    = 8'd59;
   localparam logic [7:0] ADDR_EXT_TRG_DELAY      = 8'd60;
   localparam logic [7:0] ADDR_CYCLED_TRG_PERIOD  = 8'd61;
   localparam logic [7:0] ADDR_LOGIC_GRP_OE       = 8'd62;

endpackage

`default_nettype wire

// File: rtl/trg_mon_data.sv
//------------------------------------------------------------------------------
// Module      : trg_mon_data
// Description : Registered read-back mux of the trigger monitor words, with
//               coherent shadowing of the upper halves of 32-bit counters.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module trg_mon_data
   import trg_mon_pkg::*;
#(
   parameter int BASE_ADDR = 24,
   parameter int DW        = trg_mon_pkg::DW
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            rd_in,
   input  logic [7:0]      rd_addr_in,
   input  logic [DW-1:0]   ctrl_reg_in,
   input  logic [DW-1:0]   cmd_reg_in,
   input  logic [DW-1:0]   trg_mode_mip1_in,
   input  logic [DW-1:0]   trg_mode_mip2_in,
   input  logic [DW-1:0]   trg_mode_gm1_in,
   input  logic [DW-1:0]   trg_mode_gm2_in,
   input  logic [DW-1:0]   trg_mode_ubs_in,
   input  logic [DW-1:0]   trg_mode_brst_in,
   input  logic [DW-1:0]   eff_trg_cnt_in,
   input  logic [DW-1:0]   coincid_trg_cnt_in,
   input  logic [DW-1:0]   hit_monit_fix_sel_in,
   input  logic [DW-1:0]   hit_monit_sel_in,
   input  logic [DW-1:0]   hit_monit_err_cnt_in,
   input  logic [DW-1:0]   hit_start_cnt_in,
   input  logic [2*DW-1:0] hit_monit_cnt_0_in,
   input  logic [2*DW-1:0] hit_monit_cnt_1_in,
   input  logic [DW-1:0]   busy_monit_fix_sel_in,
   input  logic [DW-1:0]   busy_monit_err_cnt_in,
   input  logic [DW-1:0]   busy_monit_cnt_in,
   input  logic [DW-1:0]   coincid_MIP1_cnt_in,
   input  logic [DW-1:0]   coincid_MIP2_cnt_in,
   input  logic [DW-1:0]   coincid_GM1_cnt_in,
   input  logic [DW-1:0]   coincid_GM2_cnt_in,
   input  logic [2*DW-1:0] coincid_UBS_cnt_in,
   input  logic [DW-1:0]   logic_match_cnt_in,
   input  logic [DW-1:0]   ext_trg_cnt_in,
   input  logic [DW-1:0]   hit_ab_sel_in,
   input  logic [DW-1:0]   busy_ab_sel_in,
   input  logic [DW-1:0]   hit_mask_in,
   input  logic [DW-1:0]   busy_mask_in,
   input  logic [DW-1:0]   trg_match_win_in,
   input  logic [DW-1:0]   trg_dead_time_in,
   input  logic [DW-1:0]   config_received_in,
   input  logic [DW-1:0]   ext_trg_delay_in,
   input  logic [DW-1:0]   cycled_trg_period_in,
   input  logic [7:0]      logic_grp_oe_in,
   output logic [DW-1:0]   mon_data_out
);

   logic [7:0]    w_norm_addr;
   logic [DW-1:0] w_mux;
   logic [DW-1:0] r_mon_data;
   logic [DW-1:0] r_shadow_hit0;
   logic [DW-1:0] r_shadow_hit1;
   logic [DW-1:0] r_shadow_ubs;

   // Rebase the incoming address onto the package map, which is anchored at 24.
   assign w_norm_addr = rd_addr_in - 8'(BASE_ADDR) + ADDR_CTRL_REG;

   always_comb begin
      w_mux = '0;
      case (w_norm_addr)
         ADDR_CTRL_REG:           w_mux = ctrl_reg_in;
         ADDR_CMD_REG:            w_mux = cmd_reg_in;
         ADDR_TRG_MODE_MIP1:      w_mux = trg_mode_mip1_in;
         ADDR_TRG_MODE_MIP2:      w_mux = trg_mode_mip2_in;
         ADDR_TRG_MODE_GM1:       w_mux = trg_mode_gm1_in;
         ADDR_TRG_MODE_GM2:       w_mux = trg_mode_gm2_in;
         ADDR_TRG_MODE_UBS:       w_mux = trg_mode_ubs_in;
         ADDR_TRG_MODE_BRST:      w_mux = trg_mode_brst_in;
         ADDR_EFF_TRG_CNT:        w_mux = eff_trg_cnt_in;
         ADDR_COINCID_TRG_CNT:    w_mux = coincid_trg_cnt_in;
         ADDR_HIT_MONIT_FIX_SEL:  w_mux = hit_monit_fix_sel_in;
         ADDR_HIT_MONIT_SEL:      w_mux = hit_monit_sel_in;
         ADDR_HIT_MONIT_ERR_CNT:  w_mux = hit_monit_err_cnt_in;
         ADDR_HIT_START_CNT:      w_mux = hit_start_cnt_in;
         ADDR_HIT_MONIT_CNT_0_LO: w_mux = hit_monit_cnt_0_in[DW-1:0];
         ADDR_HIT_MONIT_CNT_0_HI: w_mux = r_shadow_hit0;
         ADDR_HIT_MONIT_CNT_1_LO: w_mux = hit_monit_cnt_1_in[DW-1:0];
         ADDR_HIT_MONIT_CNT_1_HI: w_mux = r_shadow_hit1;
         ADDR_BUSY_MONIT_FIX_SEL: w_mux = busy_monit_fix_sel_in;
         ADDR_BUSY_MONIT_ERR_CNT: w_mux = busy_monit_err_cnt_in;
         ADDR_BUSY_MONIT_CNT:     w_mux = busy_monit_cnt_in;
         ADDR_COINCID_MIP1:       w_mux = coincid_MIP1_cnt_in;
         ADDR_COINCID_MIP2:       w_mux = coincid_MIP2_cnt_in;
         ADDR_COINCID_GM1:        w_mux = coincid_GM1_cnt_in;
         ADDR_COINCID_GM2:        w_mux = coincid_GM2_cnt_in;
         ADDR_COINCID_UBS_LO:     w_mux = coincid_UBS_cnt_in[DW-1:0];
         ADDR_COINCID_UBS_HI:     w_mux = r_shadow_ubs;
         ADDR_LOGIC_MATCH_CNT:    w_mux = logic_match_cnt_in;
         ADDR_EXT_TRG_CNT:        w_mux = ext_trg_cnt_in;
         ADDR_HIT_AB_SEL:         w_mux = hit_ab_sel_in;
         ADDR_BUSY_AB_SEL:        w_mux = busy_ab_sel_in;
         ADDR_HIT_MASK:           w_mux = hit_mask_in;
         ADDR_BUSY_MASK:          w_mux = busy_mask_in;
         ADDR_TRG_MATCH_WIN:      w_mux = trg_match_win_in;
         ADDR_TRG_DEAD_TIME:      w_mux = trg_dead_time_in;
         ADDR_CONFIG_RECEIVED:    w_mux = config_received_in;
         ADDR_EXT_TRG_DELAY:      w_mux = ext_trg_delay_in;
         ADDR_CYCLED_TRG_PERIOD:  w_mux = cycled_trg_period_in;
         ADDR_LOGIC_GRP_OE:       w_mux = {{(DW-8){1'b0}}, logic_grp_oe_in};
         default:                 w_mux = '0;
      endcase
   end

   // A low-half read freezes the upper half so the pair reads as one snapshot.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_mon_data    <= '0;
         r_shadow_hit0 <= '0;
         r_shadow_hit1 <= '0;
         r_shadow_ubs  <= '0;
      end else if (rd_in) begin
         r_mon_data <= w_mux;
         if (w_norm_addr == ADDR_HIT_MONIT_CNT_0_LO)
            r_shadow_hit0 <= hit_monit_cnt_0_in[2*DW-1:DW];
         if (w_norm_addr == ADDR_HIT_MONIT_CNT_1_LO)
            r_shadow_hit1 <= hit_monit_cnt_1_in[2*DW-1:DW];
         if (w_norm_addr == ADDR_COINCID_UBS_LO)
            r_shadow_ubs  <= coincid_UBS_cnt_in[2*DW-1:DW];
      end
   end

   assign mon_data_out = r_mon_data;

endmodule

`default_nettype wire

// File: tb/tb_trg_mon_data.sv
//------------------------------------------------------------------------------
// Module      : tb_trg_mon_data
// Description : Directed and randomized read-back checks of trg_mon_data
//               against an address-table reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_trg_mon_data;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd_in = 1'b0;
   logic [7:0]  rd_addr = 8'd0;
   logic [15:0] v16 [0:31];
   logic [31:0] v32 [0:2];
   logic [7:0]  oe;
   logic [15:0] mon_data_out;

   logic [15:0] exp_q;
   logic [15:0] sh [0:2];
   int          n_checks = 0;
   int          n_pass   = 0;

   always #5 clk = ~clk;

   trg_mon_data dut (
      .clk_in                (clk),
      .rst_in                (rst),
      .rd_in                 (rd_in),
      .rd_addr_in            (rd_addr),
      .ctrl_reg_in           (v16[0]),
      .cmd_reg_in            (v16[1]),
      .trg_mode_mip1_in      (v16[2]),
      .trg_mode_mip2_in      (v16[3]),
      .trg_mode_gm1_in       (v16[4]),
      .trg_mode_gm2_in       (v16[5]),
      .trg_mode_ubs_in       (v16[6]),
      .trg_mode_brst_in      (v16[7]),
      .eff_trg_cnt_in        (v16[8]),
      .coincid_trg_cnt_in    (v16[9]),
      .hit_monit_fix_sel_in  (v16[10]),
      .hit_monit_sel_in      (v16[11]),
      .hit_monit_err_cnt_in  (v16[12]),
      .hit_start_cnt_in      (v16[13]),
      .hit_monit_cnt_0_in    (v32[0]),
      .hit_monit_cnt_1_in    (v32[1]),
      .busy_monit_fix_sel_in (v16[14]),
      .busy_monit_err_cnt_in (v16[15]),
      .busy_monit_cnt_in     (v16[16]),
      .coincid_MIP1_cnt_in   (v16[17]),
      .coincid_MIP2_cnt_in   (v16[18]),
      .coincid_GM1_cnt_in    (v16[19]),
      .coincid_GM2_cnt_in    (v16[20]),
      .coincid_UBS_cnt_in    (v32[2]),
      .logic_match_cnt_in    (v16[21]),
      .ext_trg_cnt_in        (v16[22]),
      .hit_ab_sel_in         (v16[23]),
      .busy_ab_sel_in        (v16[24]),
      .hit_mask_in           (v16[25]),
      .busy_mask_in          (v16[26]),
      .trg_match_win_in      (v16[27]),
      .trg_dead_time_in      (v16[28]),
      .config_received_in    (v16[29]),
      .ext_trg_delay_in      (v16[30]),
      .cycled_trg_period_in  (v16[31]),
      .logic_grp_oe_in       (oe),
      .mon_data_out          (mon_data_out)
   );

   // Live word at an address, straight from the published address table.
   function automatic logic [15:0] live(input int a);
      if (a >= 24 && a <= 37) return v16[a-24];
      if (a == 38) return v32[0][15:0];
      if (a == 40) return v32[1][15:0];
      if (a >= 42 && a <= 48) return v16[a-28];
      if (a == 49) return v32[2][15:0];
      if (a >= 51 && a <= 61) return v16[a-30];
      if (a == 62) return {8'h00, oe};
      return 16'h0000;
   endfunction

   task automatic model_read(input int a);
      case (a)
         39:      exp_q = sh[0];
         41:      exp_q = sh[1];
         50:      exp_q = sh[2];
         default: exp_q = live(a);
      endcase
      if (a == 38) sh[0] = v32[0][31:16];
      if (a == 40) sh[1] = v32[1][31:16];
      if (a == 49) sh[2] = v32[2][31:16];
   endtask

   task automatic model_reset();
      exp_q = 16'h0000;
      for (int k = 0; k < 3; k++) sh[k] = 16'h0000;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step(input logic rd, input logic [7:0] addr, input string tag);
      @(negedge clk);
      rd_in   = rd;
      rd_addr = addr;
      if (rd) model_read(int'(addr));
      @(posedge clk);
      #1;
      check(tag, mon_data_out, exp_q);
   endtask

   task automatic std_stim();
      for (int k = 0; k < 32; k++) v16[k] = (k % 2 == 0) ? 16'h3553 : 16'h0003;
      v32[0] = 32'h84353553;
      v32[1] = 32'h00033553;
      v32[2] = 32'h33530003;
      oe     = 8'h13;
   endtask

   task automatic async_reset(input string tag);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check(tag, mon_data_out, exp_q);
      #1 rst = 1'b0;
   endtask

   initial begin
      std_stim();
      model_reset();
      #3;
      check("reset_out", mon_data_out, 16'h0000);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      step(1'b1, 8'd41, "hi_before_lo");
      step(1'b1, 8'd50, "ubs_hi_before_lo");

      v16[1] = 16'h0003;
      step(1'b1, 8'd25, "cmd_reg");
      v16[0] = 16'h3553;
      step(1'b1, 8'd24, "ctrl_reg");

      v32[0] = 32'h84353553;
      step(1'b1, 8'd38, "hit0_lo");
      v32[0] = 32'h11112222;
      step(1'b1, 8'd39, "hit0_hi_shadow");
      v32[2] = 32'h33330003;
      step(1'b1, 8'd49, "ubs_lo");
      v32[2] = 32'h44445555;
      step(1'b1, 8'd50, "ubs_hi_shadow");

      std_stim();
      for (int a = 25; a <= 62; a++) step(1'b1, 8'(a), "sweep");
      check("grp_oe_word", mon_data_out, 16'h0013);

      step(1'b1, 8'd23, "unmapped_23");
      step(1'b1, 8'd63, "unmapped_63");
      step(1'b1, 8'd255, "unmapped_255");

      v16[9] = 16'h3553;
      step(1'b1, 8'd33, "hold_src");
      v16[12] = 16'h0abc;
      for (int k = 0; k < 3; k++) step(1'b0, 8'd36, "hold");
      step(1'b1, 8'd36, "hold_release");

      v16[5] = 16'h1234;
      step(1'b1, 8'd29, "track0");
      v16[5] = 16'h5678;
      step(1'b1, 8'd29, "track1");

      step(1'b1, 8'd38, "pre_reset_lo");
      step(1'b1, 8'd24, "pre_reset_read");
      async_reset("reset_mid_read");
      step(1'b1, 8'd39, "shadow_cleared");

      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < 32; k++) v16[k] = 16'($urandom);
         for (int k = 0; k < 3; k++) v32[k] = $urandom;
         oe = 8'($urandom);
         if ($urandom_range(0, 9) == 0)
            step($urandom_range(0, 3) != 0, 8'($urandom), "rnd_any");
         else
            step($urandom_range(0, 3) != 0, 8'($urandom_range(20, 66)), "rnd_map");
         if ($urandom_range(0, 59) == 0) async_reset("rnd_reset");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
